usrclk_reset_sequencer: RTL and testbench

Bring-up controller for the transceiver user-clock buffers. It runs on the free-running init clock and sequences the buffer clear, waits for the buffered user clocks to report active, then releases GT user-ready and the user-clock datapath reset. It retries on timeout, restarts on clock loss, and parks in a sticky fault state once its retries are exhausted. It sits between the GT channel and the clock-buffer block in the GT wrapper.

---
 rtl/usrclk_seq_pkg.sv | 48 ++++
 rtl/sync_2ff.sv | 24 ++
 rtl/usrclk_reset_sequencer.sv | 128 ++++++++++++
 tb/tb_usrclk_reset_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usrclk_seq_pkg.sv
// rtl/usrclk_seq_pkg.sv - shared types, defaults and output decode for the user-clock reset sequencer
package usrclk_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_STABLE,
        CLR,
        WAIT_ACTIVE,
        SETTLE,
        RUN,
        FAULT
    } seq_state_t;

    localparam int DEF_CLR_CYCLES     = 16;
    localparam int DEF_ACTIVE_TIMEOUT = 4096;
    localparam int DEF_SETTLE_CYCLES  = 64;
    localparam int DEF_MAX_RETRY      = 7;

    typedef struct packed {
        logic buf_clr;
        logic gt_userrdy;
        logic datapath_rst;
        logic seq_done;
        logic fault;
    } seq_out_t;

    // WAIT_STABLE values double as the reset values of the output registers.
    function automatic seq_out_t decode_outputs(input seq_state_t s);
        seq_out_t o;
        o = '{buf_clr: 1'b1, gt_userrdy: 1'b0, datapath_rst: 1'b1, seq_done: 1'b0, fault: 1'b0};
        case (s)
            WAIT_ACTIVE: o.buf_clr = 1'b0;
            SETTLE: begin
                o.buf_clr    = 1'b0;
                o.gt_userrdy = 1'b1;
            end
            RUN: begin
                o.buf_clr      = 1'b0;
                o.gt_userrdy   = 1'b1;
                o.datapath_rst = 1'b0;
                o.seq_done     = 1'b1;
            end
            FAULT:   o.fault = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic meta;
    (* ASYNC_REG = "TRUE" *) logic sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= d;
            sync <= meta;
        end
    end

    assign q = sync;

endmodule

// File: rtl/usrclk_reset_sequencer.sv
// rtl/usrclk_reset_sequencer.sv - sequences buffer clear, usrclk activity wait and datapath reset release
module usrclk_reset_sequencer
    import usrclk_seq_pkg::*;
#(
    parameter int CLR_CYCLES     = DEF_CLR_CYCLES,
    parameter int ACTIVE_TIMEOUT = DEF_ACTIVE_TIMEOUT,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int MAX_RETRY      = DEF_MAX_RETRY,
    localparam int RETRY_W       = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               outclk_stable,
    input  logic               usrclk_active,
    input  logic               restart,
    output logic               buf_clr,
    output logic               gt_userrdy,
    output logic               datapath_rst,
    output logic               seq_done,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int CNT_MAX = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int TMR_W   = (ACTIVE_TIMEOUT > 1) ? $clog2(ACTIVE_TIMEOUT) : 1;

    localparam logic [CNT_W-1:0]   CLR_LOAD    = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]   TMR_LAST    = TMR_W'(ACTIVE_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRY);

    logic stable_s;
    logic active_s;

    seq_state_t         state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [TMR_W-1:0]   tmr, tmr_nxt;
    logic [RETRY_W-1:0] retry_q, retry_nxt;
    seq_out_t           out_q;

    sync_2ff u_sync_stable (.clk(clk), .rst_n(rst_n), .d(outclk_stable), .q(stable_s));
    sync_2ff u_sync_active (.clk(clk), .rst_n(rst_n), .d(usrclk_active), .q(active_s));

    // restart outranks clock loss, and both outrank any counter expiry in the same cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tmr_nxt   = tmr;
        retry_nxt = retry_q;
        if (restart) begin
            state_nxt = WAIT_STABLE;
            retry_nxt = '0;
        end else if (!stable_s && (state inside {CLR, WAIT_ACTIVE, SETTLE, RUN})) begin
            state_nxt = WAIT_STABLE;
        end else begin
            case (state)
                WAIT_STABLE: begin
                    if (stable_s) begin
                        state_nxt = CLR;
                        cnt_nxt   = CLR_LOAD;
                    end
                end
                CLR: begin
                    if (cnt == '0) begin
                        state_nxt = WAIT_ACTIVE;
                        tmr_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                WAIT_ACTIVE: begin
                    if (active_s) begin
                        state_nxt = SETTLE;
                        cnt_nxt   = SETTLE_LOAD;
                    end else if (tmr == TMR_LAST) begin
                        if (retry_q == RETRY_LAST) begin
                            state_nxt = FAULT;
                        end else begin
                            state_nxt = CLR;
                            cnt_nxt   = CLR_LOAD;
                            retry_nxt = retry_q + RETRY_W'(1);
                        end
                    end else begin
                        tmr_nxt = tmr + TMR_W'(1);
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state_nxt = RUN;
                        retry_nxt = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!active_s) state_nxt = WAIT_STABLE;
                end
                FAULT:   ;
                default: state_nxt = WAIT_STABLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= WAIT_STABLE;
            cnt     <= '0;
            tmr     <= '0;
            retry_q <= '0;
            out_q   <= decode_outputs(WAIT_STABLE);
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            tmr     <= tmr_nxt;
            retry_q <= retry_nxt;
            out_q   <= decode_outputs(state_nxt);
        end
    end

    assign buf_clr      = out_q.buf_clr;
    assign gt_userrdy   = out_q.gt_userrdy;
    assign datapath_rst = out_q.datapath_rst;
    assign seq_done     = out_q.seq_done;
    assign fault        = out_q.fault;
    assign retry_cnt    = retry_q;

endmodule

// File: tb/tb_usrclk_reset_sequencer.sv
// tb/tb_usrclk_reset_sequencer.sv - self-checking bench for usrclk_reset_sequencer
module tb_usrclk_reset_sequencer;

    localparam int CLR_C = 4;
    localparam int TO_C  = 16;
    localparam int SET_C = 8;
    localparam int MAX_R = 2;
    localparam int RW    = 2;

    // {buf_clr, gt_userrdy, datapath_rst, seq_done, fault}
    localparam logic [4:0] O_IDLE = 5'b10100;
    localparam logic [4:0] O_WAIT = 5'b00100;
    localparam logic [4:0] O_SET  = 5'b01100;
    localparam logic [4:0] O_RUN  = 5'b01010;
    localparam logic [4:0] O_FLT  = 5'b10101;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic outclk_stable = 1'b0;
    logic usrclk_active = 1'b0;
    logic restart = 1'b0;
    logic buf_clr, gt_userrdy, datapath_rst, seq_done, fault;
    logic [RW-1:0] retry_cnt;

    int checks = 0;
    int errors = 0;

    usrclk_reset_sequencer #(
        .CLR_CYCLES(CLR_C), .ACTIVE_TIMEOUT(TO_C), .SETTLE_CYCLES(SET_C), .MAX_RETRY(MAX_R)
    ) dut (
        .clk(clk), .rst_n(rst_n), .outclk_stable(outclk_stable), .usrclk_active(usrclk_active),
        .restart(restart), .buf_clr(buf_clr), .gt_userrdy(gt_userrdy), .datapath_rst(datapath_rst),
        .seq_done(seq_done), .fault(fault), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [6:0] want);
        logic [6:0] got;
        got = {buf_clr, gt_userrdy, datapath_rst, seq_done, fault, retry_cnt};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, got, want);
        end
    endtask

    // Reference model: phases count cycles spent upward; async inputs become visible two edges late.
    localparam int P_IDLE = 10, P_CLEAR = 11, P_WAIT = 12, P_SETTLE = 13, P_RUN = 14, P_FAULT = 15;
    int m_phase = P_IDLE;
    int m_spent = 0;
    int m_retry = 0;
    bit st_hist[$];
    bit act_hist[$];
    bit seen_st, seen_act;

    task automatic m_go(input int p);
        m_phase = p;
        m_spent = 0;
    endtask

    function automatic logic [6:0] m_expect();
        logic [4:0] o;
        case (m_phase)
            P_WAIT:   o = O_WAIT;
            P_SETTLE: o = O_SET;
            P_RUN:    o = O_RUN;
            P_FAULT:  o = O_FLT;
            default:  o = O_IDLE;
        endcase
        return {o, RW'(m_retry)};
    endfunction

    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_go(P_IDLE);
            m_retry = 0;
            st_hist.delete();
            act_hist.delete();
            repeat (2) begin
                st_hist.push_back(1'b0);
                act_hist.push_back(1'b0);
            end
        end else begin
            seen_st  = st_hist.pop_front();
            seen_act = act_hist.pop_front();
            st_hist.push_back(outclk_stable);
            act_hist.push_back(usrclk_active);
            if (restart) begin
                m_go(P_IDLE);
                m_retry = 0;
            end else if (!seen_st && m_phase inside {P_CLEAR, P_WAIT, P_SETTLE, P_RUN}) begin
                m_go(P_IDLE);
            end else begin
                case (m_phase)
                    P_IDLE:  if (seen_st) m_go(P_CLEAR);
                    P_CLEAR: if (m_spent == CLR_C - 1) m_go(P_WAIT); else m_spent++;
                    P_WAIT: begin
                        if (seen_act) m_go(P_SETTLE);
                        else if (m_spent == TO_C - 1) begin
                            if (m_retry == MAX_R) m_go(P_FAULT);
                            else begin
                                m_retry++;
                                m_go(P_CLEAR);
                            end
                        end else m_spent++;
                    end
                    P_SETTLE: begin
                        if (m_spent == SET_C - 1) begin
                            m_go(P_RUN);
                            m_retry = 0;
                        end else m_spent++;
                    end
                    P_RUN:   if (!seen_act) m_go(P_IDLE);
                    default: ;
                endcase
            end
        end
    end

    always begin
        @(negedge clk);
        if (rst_n) cmp("model", m_expect());
    end

    typedef struct {
        logic       st;
        logic       act;
        logic       rs;
        int         n;
        logic [6:0] want;
    } vec_t;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic st, input logic act);
        rst_n = 1'b0;
        outclk_stable = st;
        usrclk_active = 1'b0;
        restart = 1'b0;
        step(2);
        rst_n = 1'b1;
        usrclk_active = act;
    endtask

    task automatic run_random(input int cycles);
        int act_hold = 0;
        int st_hold = 0;
        for (int i = 0; i < cycles; i++) begin
            if (act_hold == 0) begin
                usrclk_active = 1'($urandom_range(0, 1));
                act_hold = $urandom_range(1, 80);
            end else act_hold--;
            if (st_hold == 0) begin
                outclk_stable = ($urandom_range(0, 149) != 0);
                st_hold = outclk_stable ? 0 : $urandom_range(1, 6);
            end else st_hold--;
            restart = ($urandom_range(0, 299) == 0);
            step(1);
        end
        restart = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end by %0t", $time);
        $fatal(1);
    end

    initial begin
        vec_t nom[12];
        nom[0]  = '{1'b1, 1'b0, 1'b0, 0, {O_IDLE, 2'd0}};
        nom[1]  = '{1'b1, 1'b0, 1'b0, 6, {O_IDLE, 2'd0}};
        nom[2]  = '{1'b1, 1'b0, 1'b0, 1, {O_WAIT, 2'd0}};
        nom[3]  = '{1'b1, 1'b0, 1'b0, 2, {O_WAIT, 2'd0}};
        nom[4]  = '{1'b1, 1'b1, 1'b0, 2, {O_WAIT, 2'd0}};
        nom[5]  = '{1'b1, 1'b1, 1'b0, 1, {O_SET,  2'd0}};
        nom[6]  = '{1'b1, 1'b1, 1'b0, 7, {O_SET,  2'd0}};
        nom[7]  = '{1'b1, 1'b1, 1'b0, 1, {O_RUN,  2'd0}};
        nom[8]  = '{1'b1, 1'b0, 1'b0, 2, {O_RUN,  2'd0}};
        nom[9]  = '{1'b1, 1'b0, 1'b0, 1, {O_IDLE, 2'd0}};
        nom[10] = '{1'b1, 1'b0, 1'b0, 4, {O_IDLE, 2'd0}};
        nom[11] = '{1'b1, 1'b0, 1'b0, 1, {O_WAIT, 2'd0}};

        do_reset(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            outclk_stable = nom[i].st;
            usrclk_active = nom[i].act;
            restart = nom[i].rs;
            step(nom[i].n);
            cmp($sformatf("nominal[%0d]", i), nom[i].want);
        end

        do_reset(1'b1, 1'b0);
        step(22); cmp("timeout_wait_end", {O_WAIT, 2'd0});
        step(1);  cmp("timeout_reclr",    {O_IDLE, 2'd1});
        step(3);  cmp("timeout_clr_hold", {O_IDLE, 2'd1});
        step(1);  cmp("timeout_wait2",    {O_WAIT, 2'd1});
        usrclk_active = 1'b1;
        step(2);  cmp("timeout_sync_lat", {O_WAIT, 2'd1});
        step(1);  cmp("timeout_settle",   {O_SET,  2'd1});
        step(7);  cmp("timeout_settle_e", {O_SET,  2'd1});
        step(1);  cmp("timeout_run",      {O_RUN,  2'd0});

        do_reset(1'b1, 1'b0);
        step(62); cmp("exhaust_last_wait", {O_WAIT, 2'd2});
        step(1);  cmp("exhaust_fault",     {O_FLT,  2'd2});
        step(7);  cmp("exhaust_fault_hold", {O_FLT, 2'd2});
        restart = 1'b1;
        step(1);  cmp("exhaust_restart",   {O_IDLE, 2'd0});
        restart = 1'b0;
        step(4);  cmp("exhaust_rerun_clr", {O_IDLE, 2'd0});
        step(1);  cmp("exhaust_rerun_wait", {O_WAIT, 2'd0});

        do_reset(1'b1, 1'b1);
        step(13); cmp("prec_settle", {O_SET, 2'd0});
        outclk_stable = 1'b0;
        step(2);  cmp("prec_settle_last", {O_SET,  2'd0});
        step(1);  cmp("prec_stable_wins", {O_IDLE, 2'd0});
        outclk_stable = 1'b1;

        do_reset(1'b1, 1'b0);
        step(4);
        restart = 1'b1;
        step(1);  cmp("restart_in_clr", {O_IDLE, 2'd0});
        restart = 1'b0;
        step(4);  cmp("restart_clr_reloaded", {O_IDLE, 2'd0});
        step(1);  cmp("restart_clr_wait", {O_WAIT, 2'd0});

        do_reset(1'b1, 1'b1);
        step(16); cmp("restart_run_pre", {O_RUN, 2'd0});
        restart = 1'b1;
        step(1);  cmp("restart_in_run", {O_IDLE, 2'd0});
        restart = 1'b0;

        do_reset(1'b1, 1'b1);
        step(10); cmp("async_pre", {O_SET, 2'd0});
        #2 rst_n = 1'b0;
        #1 cmp("async_reset", {O_IDLE, 2'd0});

        do_reset(1'b1, 1'b0);
        run_random(4000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
